// File: rtl/fifo_burst_ctrl_pkg.sv
// Shared types, default widths and the saturating-increment helper for the FIFO burst controller.
package fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_BURST = 2'd2,
    ST_TAIL  = 2'd3
  } state_e;

  localparam int DW_DEF        = 8;
  localparam int DC_W_DEF      = 8;
  localparam int BURST_LEN_DEF = 16;
  localparam int RST_CYC_DEF   = 4;
  localparam int BCNT_W        = 16;
  localparam int ECNT_W        = 8;

  // Widths up to 32 bits; the value sticks at the all-ones ceiling of width w.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max;
    max = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max) ? max : v + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_burst_ctrl_if.sv
// Controller <-> FIFO bundle; master is the controller side, slave the FIFO side.
interface fifo_burst_ctrl_if #(
  parameter int DW   = 8,
  parameter int DC_W = 8
);
  logic            srst;
  logic [DW-1:0]   din;
  logic            wr_en;
  logic            rd_en;
  logic [DW-1:0]   dout;
  logic            full;
  logic            empty;
  logic            valid;
  logic            overflow;
  logic            underflow;
  logic [DC_W-1:0] data_count;

  modport master (
    output srst, din, wr_en, rd_en,
    input  dout, full, empty, valid, overflow, underflow, data_count
  );

  modport slave (
    input  srst, din, wr_en, rd_en,
    output dout, full, empty, valid, overflow, underflow, data_count
  );
endinterface

// File: rtl/fifo_burst_ctrl_sat_cnt.sv
// W-bit saturating event counter with synchronous clear.
module sat_cnt
  import fifo_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         srst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = W'(sat_inc(32'(cnt_q), W));
  end

  always_ff @(posedge clk) begin
    if (!srst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fifo_burst_ctrl.sv
// Burst sequencer for a synchronous FIFO: gated writes, timed FIFO reset window,
// fixed-length (or flushed short) read bursts and saturating status counters.
module fifo_burst_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int DC_W      = DC_W_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int RST_CYC   = RST_CYC_DEF
) (
  input  logic              clk,
  input  logic              srst_n,
  input  logic              en,
  input  logic              clr,
  input  logic              flush,
  input  logic              s_valid,
  input  logic [DW-1:0]     s_data,
  output logic              s_ready,
  input  logic              burst_rdy,
  output logic              m_valid,
  output logic [DW-1:0]     m_data,
  output logic              m_last,
  fifo_burst_ctrl_if.master fifo,
  output logic [BCNT_W-1:0] burst_cnt,
  output logic [ECNT_W-1:0] ovf_cnt,
  output logic [ECNT_W-1:0] unf_cnt
);

  localparam int              RCW      = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RCW-1:0]  RST_LAST = RCW'(RST_CYC - 1);
  localparam logic [DC_W-1:0] BLEN     = DC_W'(BURST_LEN);

  state_e          state_q;
  logic [RCW-1:0]  rst_cnt_q;
  logic [DC_W-1:0] rem_q;
  logic            m_last_q;

  logic rd_en, start_full, start_short, burst_done;

  // Reads only issue against a non-empty FIFO; a stalled cycle leaves rem untouched.
  assign rd_en       = (state_q == ST_BURST) && !fifo.empty;
  assign start_full  = en && burst_rdy && (fifo.data_count >= BLEN);
  assign start_short = en && burst_rdy && flush && !fifo.empty;
  assign burst_done  = (state_q == ST_TAIL) && !clr;

  always_ff @(posedge clk) begin
    if (!srst_n || clr) begin
      state_q   <= ST_RST;
      rst_cnt_q <= '0;
      rem_q     <= '0;
      m_last_q  <= 1'b0;
    end else begin
      m_last_q <= 1'b0;
      unique case (state_q)
        ST_RST: begin
          if (rst_cnt_q == RST_LAST) state_q   <= ST_IDLE;
          else                       rst_cnt_q <= rst_cnt_q + 1'b1;
        end
        ST_IDLE: begin
          if (start_full) begin
            rem_q   <= BLEN;
            state_q <= ST_BURST;
          end else if (start_short) begin
            rem_q   <= fifo.data_count;
            state_q <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (rd_en) begin
            rem_q <= rem_q - 1'b1;
            // Final read issues now; its data and m_last land together next cycle.
            if (rem_q == DC_W'(1)) begin
              state_q  <= ST_TAIL;
              m_last_q <= 1'b1;
            end
          end
        end
        ST_TAIL: state_q <= ST_IDLE;
        default: state_q <= ST_RST;
      endcase
    end
  end

  assign s_ready    = (state_q != ST_RST) && !fifo.full;
  assign fifo.wr_en = s_valid && s_ready;
  assign fifo.din   = s_data;
  assign fifo.rd_en = rd_en;
  assign fifo.srst  = (state_q == ST_RST);

  assign m_valid = fifo.valid;
  assign m_data  = fifo.dout;
  assign m_last  = m_last_q;

  sat_cnt #(.W(BCNT_W)) u_burst_cnt (
    .clk(clk), .srst_n(srst_n), .inc_i(burst_done), .clr_i(1'b0), .cnt_o(burst_cnt)
  );

  sat_cnt #(.W(ECNT_W)) u_ovf_cnt (
    .clk(clk), .srst_n(srst_n), .inc_i(fifo.overflow), .clr_i(1'b0), .cnt_o(ovf_cnt)
  );

  sat_cnt #(.W(ECNT_W)) u_unf_cnt (
    .clk(clk), .srst_n(srst_n), .inc_i(fifo.underflow), .clr_i(1'b0), .cnt_o(unf_cnt)
  );

endmodule

// File: tb/tb_fifo_burst_ctrl.sv
// Directed bench: 32-deep FIFO model on the slave side, table of reset/clear cycles, then burst scenarios.
module tb_fifo_burst_ctrl;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        srst_n, en, clr, flush, s_valid, burst_rdy;
  logic [7:0]  s_data;
  logic        s_ready, m_valid, m_last;
  logic [7:0]  m_data;
  logic [15:0] burst_cnt;
  logic [7:0]  ovf_cnt, unf_cnt;
  logic        inj_ovf, inj_unf;

  fifo_burst_ctrl_if #(.DW(8), .DC_W(8)) fif ();

  fifo_burst_ctrl dut (
    .clk(clk), .srst_n(srst_n), .en(en), .clr(clr), .flush(flush),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .burst_rdy(burst_rdy),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .fifo(fif),
    .burst_cnt(burst_cnt), .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt)
  );

  always #5 clk = ~clk;

  // FIFO model: registered read data, valid one cycle after rd_en.
  logic [7:0] mem [0:DEPTH-1];
  logic [4:0] wp = '0, rp = '0;
  int         cnt = 0;
  logic [7:0] dout_q = '0;
  logic       valid_q = 1'b0, ovf_q = 1'b0, unf_q = 1'b0;
  logic       do_wr, do_rd;

  assign do_wr = fif.wr_en && (cnt < DEPTH);
  assign do_rd = fif.rd_en && (cnt > 0);

  always @(posedge clk) begin
    if (fif.srst === 1'b1) begin
      wp <= '0; rp <= '0; cnt <= 0;
      valid_q <= 1'b0; ovf_q <= 1'b0; unf_q <= 1'b0;
    end else begin
      valid_q <= do_rd;
      if (do_rd) begin dout_q <= mem[rp]; rp <= rp + 5'd1; end
      if (do_wr) begin mem[wp] <= fif.din; wp <= wp + 5'd1; end
      cnt   <= cnt + int'(do_wr) - int'(do_rd);
      ovf_q <= fif.wr_en && (cnt == DEPTH);
      unf_q <= fif.rd_en && (cnt == 0);
    end
  end

  assign fif.dout       = dout_q;
  assign fif.valid      = valid_q;
  assign fif.full       = (cnt == DEPTH);
  assign fif.empty      = (cnt == 0);
  assign fif.data_count = 8'(cnt);
  assign fif.overflow   = ovf_q | inj_ovf;
  assign fif.underflow  = unf_q | inj_unf;

  int n_cmp = 0, n_bad = 0;
  logic       rd_hist [$];
  logic [8:0] rdata   [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
    rd_hist.push_back(fif.rd_en);
    if (m_valid) rdata.push_back({m_last, m_data});
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    to_neg();
    to_pos();
  endtask

  task automatic clear_logs();
    rd_hist.delete();
    rdata.delete();
  endtask

  function automatic int ones();
    int s = 0;
    foreach (rd_hist[i]) s += int'(rd_hist[i]);
    return s;
  endfunction

  task automatic rd_runs(output int nr, output int len0, output int len1, output int gap01);
    int cur = 0, gap = 0;
    nr = 0; len0 = 0; len1 = 0; gap01 = 0;
    foreach (rd_hist[i]) begin
      if (rd_hist[i]) begin
        if (cur == 0 && nr == 1) gap01 = gap;
        cur++;
      end else if (cur > 0) begin
        if (nr == 0) len0 = cur; else if (nr == 1) len1 = cur;
        nr++; cur = 0; gap = 1;
      end else gap++;
    end
    if (cur > 0) begin
      if (nr == 0) len0 = cur; else if (nr == 1) len1 = cur;
      nr++;
    end
  endtask

  task automatic write_words(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = base + 8'(i);
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_burst(input logic [15:0] target, input string nm);
    int n = 0;
    while (burst_cnt != target && n < 200) begin tick(); n++; end
    chk(nm, 32'(burst_cnt), 32'(target));
  endtask

  typedef struct {
    logic srst_n, clr, s_valid;
    logic e_srst, e_ready, e_wr;
  } vec_t;

  vec_t tbl [18];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nr, l0, l1, g;
    int n;
    bit full_seen, wr, any_last;
    logic [15:0] bc;

    // {srst_n, clr, s_valid, exp fifo_srst, exp s_ready, exp wr_en}
    tbl[0]  = '{0,0,0, 1,0,0};
    tbl[1]  = '{0,0,1, 1,0,0};
    tbl[2]  = '{0,0,0, 1,0,0};
    tbl[3]  = '{1,0,0, 1,0,0};
    tbl[4]  = '{1,0,1, 1,0,0};
    tbl[5]  = '{1,0,0, 1,0,0};
    tbl[6]  = '{1,0,0, 1,0,0};
    tbl[7]  = '{1,0,0, 0,1,0};
    tbl[8]  = '{1,0,1, 0,1,1};
    tbl[9]  = '{1,1,0, 0,1,0};
    tbl[10] = '{1,0,0, 1,0,0};
    tbl[11] = '{1,0,1, 1,0,0};
    tbl[12] = '{1,1,0, 1,0,0};
    tbl[13] = '{1,0,0, 1,0,0};
    tbl[14] = '{1,0,0, 1,0,0};
    tbl[15] = '{1,0,0, 1,0,0};
    tbl[16] = '{1,0,0, 1,0,0};
    tbl[17] = '{1,0,0, 0,1,0};

    srst_n = 0; en = 0; clr = 0; flush = 0; s_valid = 0; s_data = 8'hEE;
    burst_rdy = 0; inj_ovf = 0; inj_unf = 0;
    to_pos();

    // Reset window, clr from IDLE and clr restarting the window inside RST.
    for (int i = 0; i < 18; i++) begin
      srst_n  = tbl[i].srst_n;
      clr     = tbl[i].clr;
      s_valid = tbl[i].s_valid;
      to_neg();
      chk($sformatf("row%0d_fifo_srst", i), 32'(fif.srst),  32'(tbl[i].e_srst));
      chk($sformatf("row%0d_s_ready", i),   32'(s_ready),   32'(tbl[i].e_ready));
      chk($sformatf("row%0d_wr_en", i),     32'(fif.wr_en), 32'(tbl[i].e_wr));
      chk($sformatf("row%0d_rd_en", i),     32'(fif.rd_en), 32'd0);
      chk($sformatf("row%0d_m_last", i),    32'(m_last),    32'd0);
      to_pos();
    end
    clr = 0; s_valid = 0;
    chk("post_clr_count", 32'(fif.data_count), 32'd0);
    chk("reset_burst_cnt", 32'(burst_cnt), 32'd0);

    // Normal 16-word burst.
    clear_logs();
    en = 1; burst_rdy = 1;
    write_words(8'h00, 16);
    wait_burst(16'd1, "normal_burst_cnt");
    tick();
    chk("normal_nwords", 32'(rdata.size()), 32'd16);
    for (int i = 0; i < 16 && i < rdata.size(); i++) begin
      chk($sformatf("normal_data%0d", i), 32'(rdata[i][7:0]), 32'(i));
      chk($sformatf("normal_last%0d", i), 32'(rdata[i][8]),   32'(i == 15));
    end
    rd_runs(nr, l0, l1, g);
    chk("normal_runs", 32'(nr), 32'd1);
    chk("normal_runlen", 32'(l0), 32'd16);
    chk("normal_empty", 32'(fif.empty), 32'd1);

    // Fill to full with the consumer blocked.
    clear_logs();
    burst_rdy = 0; s_valid = 1; s_data = 8'h00;
    full_seen = 0; n = 0;
    while (!full_seen && n < 80) begin
      to_neg();
      wr = fif.wr_en;
      if (fif.full) begin
        full_seen = 1;
        chk("full_s_ready", 32'(s_ready), 32'd0);
        chk("full_wr_en", 32'(fif.wr_en), 32'd0);
      end
      to_pos();
      if (wr) s_data = s_data + 8'd1;
      n++;
    end
    chk("full_reached", 32'(full_seen), 32'd1);
    for (int i = 0; i < 3; i++) begin
      to_neg();
      chk($sformatf("full_hold_wr%0d", i), 32'(fif.wr_en), 32'd0);
      to_pos();
    end
    s_valid = 0;
    chk("full_count", 32'(fif.data_count), 32'd32);
    chk("full_ovf_cnt", 32'(ovf_cnt), 32'd0);
    chk("full_no_reads", 32'(ones()), 32'd0);

    // Back-to-back: en low holds off bursts, then two bursts drain all 32 words.
    clear_logs();
    en = 0; burst_rdy = 1;
    repeat (5) tick();
    chk("en_low_no_reads", 32'(ones()), 32'd0);
    en = 1;
    wait_burst(16'd3, "b2b_burst_cnt");
    tick();
    chk("b2b_nwords", 32'(rdata.size()), 32'd32);
    for (int i = 0; i < 32 && i < rdata.size(); i++) begin
      chk($sformatf("b2b_data%0d", i), 32'(rdata[i][7:0]), 32'(i));
      chk($sformatf("b2b_last%0d", i), 32'(rdata[i][8]),   32'(i == 15 || i == 31));
    end
    rd_runs(nr, l0, l1, g);
    chk("b2b_runs", 32'(nr), 32'd2);
    chk("b2b_len0", 32'(l0), 32'd16);
    chk("b2b_len1", 32'(l1), 32'd16);
    chk("b2b_gap", 32'(g), 32'd2);

    // Flush: short burst of the 5 buffered words.
    clear_logs();
    write_words(8'hA0, 5);
    repeat (3) tick();
    chk("flush_wait_no_reads", 32'(ones()), 32'd0);
    flush = 1;
    wait_burst(16'd4, "flush_burst_cnt");
    flush = 0;
    tick();
    chk("flush_nwords", 32'(rdata.size()), 32'd5);
    for (int i = 0; i < 5 && i < rdata.size(); i++) begin
      chk($sformatf("flush_data%0d", i), 32'(rdata[i][7:0]), 32'(8'hA0 + 8'(i)));
      chk($sformatf("flush_last%0d", i), 32'(rdata[i][8]),   32'(i == 4));
    end
    rd_runs(nr, l0, l1, g);
    chk("flush_runlen", 32'(l0), 32'd5);
    chk("flush_empty", 32'(fif.empty), 32'd1);
    chk("flush_unf_cnt", 32'(unf_cnt), 32'd0);

    // Abort: clr in the cycle of the 7th read.
    clear_logs();
    burst_rdy = 0;
    write_words(8'h40, 16);
    bc = burst_cnt;
    burst_rdy = 1;
    n = 0;
    while (ones() < 6 && n < 60) begin tick(); n++; end
    clr = 1;
    to_neg();
    chk("abort_7th_rd", 32'(fif.rd_en), 32'd1);
    to_pos();
    clr = 0; burst_rdy = 0;
    for (int i = 0; i < 4; i++) begin
      to_neg();
      chk($sformatf("abort_srst%0d", i), 32'(fif.srst),  32'd1);
      chk($sformatf("abort_rd%0d", i),   32'(fif.rd_en), 32'd0);
      to_pos();
    end
    to_neg();
    chk("abort_srst_done", 32'(fif.srst), 32'd0);
    chk("abort_idle_ready", 32'(s_ready), 32'd1);
    to_pos();
    tick();
    any_last = 0;
    foreach (rdata[i]) any_last |= rdata[i][8];
    chk("abort_reads", 32'(ones()), 32'd7);
    chk("abort_nwords", 32'(rdata.size()), 32'd7);
    chk("abort_no_last", 32'(any_last), 32'd0);
    chk("abort_burst_cnt", 32'(burst_cnt), 32'(bc));
    chk("abort_count", 32'(fif.data_count), 32'd0);

    // Error counters: counting, saturation, and srst_n clearing everything.
    inj_ovf = 1; repeat (3) tick(); inj_ovf = 0;
    chk("ovf_cnt3", 32'(ovf_cnt), 32'd3);
    inj_unf = 1; repeat (2) tick(); inj_unf = 0;
    chk("unf_cnt2", 32'(unf_cnt), 32'd2);
    inj_ovf = 1; repeat (300) tick(); inj_ovf = 0;
    chk("ovf_cnt_sat", 32'(ovf_cnt), 32'd255);
    chk("unf_cnt_hold", 32'(unf_cnt), 32'd2);
    srst_n = 0;
    tick();
    chk("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    chk("rst_unf_cnt", 32'(unf_cnt), 32'd0);
    chk("rst_burst_cnt", 32'(burst_cnt), 32'd0);
    chk("rst_fifo_srst", 32'(fif.srst), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
